// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with a terminal-count pulse, a sticky expiry flag,
// and one-shot or auto-reload (periodic tick) operation.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] init,
  input  logic             en,
  input  logic             auto_reload,
  input  logic             ack,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy,
  output logic             tc_pulse,
  output logic             expired
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             exp_q, exp_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    exp_d    = exp_q & ~ack;
    if (load) begin
      // A load discards any expiry that would have happened on this edge.
      cnt_d    = init;
      reload_d = init;
      exp_d    = 1'b0;
      state_d  = (init != '0) ? COUNT : IDLE;
    end else if (state_q == COUNT && en) begin
      if (cnt_q == ONE) begin
        tc_d  = 1'b1;
        exp_d = 1'b1;
        if (auto_reload) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      exp_q    <= exp_d;
    end
  end

  assign out      = cnt_q;
  assign zero     = (cnt_q == '0);
  assign busy     = (state_q == COUNT);
  assign tc_pulse = tc_q;
  assign expired  = exp_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: directed scenarios pinned with literal values, then
// random traffic, all checked every cycle against a behavioural timer model.
module tb_down_counter_timer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, load, en, auto_reload, ack;
  logic [W-1:0] init;
  logic [W-1:0] out;
  logic         zero, busy, tc_pulse, expired;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .init(init), .en(en),
    .auto_reload(auto_reload), .ack(ack), .out(out), .zero(zero),
    .busy(busy), .tc_pulse(tc_pulse), .expired(expired)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: a timer that is either running or not, holding a remaining count.
  int m_out, m_rel;
  bit m_run, m_tc, m_exp, m_valid = 1'b0;

  always @(posedge clk) begin
    bit fire;
    fire = 1'b0;
    if (!rst_n) begin
      m_out = 0; m_rel = 0; m_run = 0; m_tc = 0; m_exp = 0; m_valid = 1;
    end else if (m_valid) begin
      fire = m_run && en && (m_out == 1) && !load;
      if (load) begin
        m_out = int'(init); m_rel = int'(init); m_run = (init != 0);
        m_tc = 0; m_exp = 0;
      end else begin
        m_tc = fire;
        if (fire) begin
          m_exp = 1;
          if (auto_reload) m_out = m_rel;
          else begin m_out = 0; m_run = 0; end
        end else begin
          if (ack) m_exp = 0;
          if (m_run && en) m_out = m_out - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("out",      32'(out),      32'(m_out));
      chk("zero",     32'(zero),     32'(m_out == 0));
      chk("busy",     32'(busy),     32'(m_run));
      chk("tc_pulse", 32'(tc_pulse), 32'(m_tc));
      chk("expired",  32'(expired),  32'(m_exp));
    end
  end

  task automatic cyc(input logic l, input logic [W-1:0] i, input logic e,
                     input logic ar, input logic a);
    load = l; init = i; en = e; auto_reload = ar; ack = a;
    @(posedge clk);
    #1;
  endtask

  int pulses;

  initial begin
    rst_n = 1'b0; load = 0; init = 0; en = 0; auto_reload = 0; ack = 0;

    // 1: reset beats load
    cyc(1, 4'd9, 1, 0, 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_exp", 32'(expired), 0);
    chk("rst_tc", 32'(tc_pulse), 0);
    rst_n = 1'b1;

    // 2: one-shot 3,2,1,0
    cyc(1, 4'd3, 1, 0, 0); chk("os_load", 32'(out), 3);
    cyc(0, 4'd0, 1, 0, 0); chk("os_2", 32'(out), 2); chk("os_tc2", 32'(tc_pulse), 0);
    cyc(0, 4'd0, 1, 0, 0); chk("os_1", 32'(out), 1);
    cyc(0, 4'd0, 1, 0, 0); chk("os_0", 32'(out), 0); chk("os_tc0", 32'(tc_pulse), 1);
    chk("os_exp", 32'(expired), 1); chk("os_busy", 32'(busy), 0);
    cyc(0, 4'd0, 1, 0, 0); chk("os_hold", 32'(out), 0); chk("os_tc_clr", 32'(tc_pulse), 0);

    // 3: auto-reload period 4
    cyc(1, 4'd4, 1, 1, 0); chk("ar_load", 32'(out), 4);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(0, 4'd0, 1, 1, 0);
      if (tc_pulse) pulses++;
    end
    chk("ar_pulses", 32'(pulses), 3);
    chk("ar_out", 32'(out), 4);

    // 4: en gating then reload mid-count
    cyc(1, 4'd5, 0, 0, 0);
    cyc(0, 4'd0, 1, 0, 0); chk("en_1", 32'(out), 4);
    cyc(0, 4'd0, 0, 0, 0); chk("en_0", 32'(out), 4);
    cyc(0, 4'd0, 1, 0, 0); chk("en_1b", 32'(out), 3);
    cyc(0, 4'd0, 0, 0, 0); chk("en_0b", 32'(out), 3);
    cyc(1, 4'd2, 1, 0, 0); chk("reld", 32'(out), 2); chk("reld_tc", 32'(tc_pulse), 0);

    // 5: set beats ack, then ack clears; load 0 goes idle
    cyc(0, 4'd0, 1, 0, 0); chk("ack_pre", 32'(out), 1);
    cyc(0, 4'd0, 1, 0, 1); chk("ack_set", 32'(expired), 1); chk("ack_tc", 32'(tc_pulse), 1);
    cyc(0, 4'd0, 0, 0, 1); chk("ack_clr", 32'(expired), 0);
    cyc(1, 4'd0, 1, 0, 0); chk("ld0_busy", 32'(busy), 0); chk("ld0_tc", 32'(tc_pulse), 0);
    chk("ld0_zero", 32'(zero), 1);

    // 6: full-scale count, then reset mid-count
    cyc(1, 4'd15, 1, 0, 0);
    for (int k = 0; k < 14; k++) cyc(0, 4'd0, 1, 0, 0);
    chk("fs_14", 32'(out), 1); chk("fs_tc14", 32'(tc_pulse), 0);
    cyc(0, 4'd0, 1, 0, 0); chk("fs_tc", 32'(tc_pulse), 1); chk("fs_out", 32'(out), 0);
    cyc(1, 4'd15, 1, 0, 0);
    cyc(0, 4'd0, 1, 0, 0); cyc(0, 4'd0, 1, 0, 0);
    rst_n = 1'b0;
    cyc(0, 4'd0, 1, 0, 0); chk("mid_rst_out", 32'(out), 0); chk("mid_rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

    // Random traffic; small inits are favoured so expiries are frequent.
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      cyc(($urandom_range(0, 99) < 8),
          ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 4)),
          ($urandom_range(0, 9) < 7),
          W'($urandom_range(0, 1)) != 0,
          ($urandom_range(0, 99) < 15));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
